lcd_reader: RTL and testbench
=============================

LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter T_SETUP, default 3: clk cycles from RS/RW valid to E rising (tAS).
REQ-002 Parameter T_EHIGH, default 12: clk cycles E held high; data sampled on the last cycle.
REQ-003 Parameter T_HOLD, default 12: clk cycles E low before the next access or return to idle.
REQ-004 Parameter POLL_MAX, default 4000: maximum busy-flag reads per poll request.
REQ-005 clk  in  1  single system clock, all logic on rising edge.
REQ-006 resetn  in  1  reset, asynchronous, active-high despite the name.
REQ-007 req  in  1  start one read transaction; sampled only in IDLE.
REQ-008 rs_sel  in  1  0 = busy-flag/address read, 1 = DDRAM/CGRAM data read; captured with req.
REQ-009 poll  in  1  with rs_sel=0, repeat BF reads until BF=0; captured with req.
REQ-010 rdata  out  8  last sampled LCD byte.
REQ-011 bf  out  1  rdata[7] when the last read had rs_sel=0, else holds its previous value.
REQ-012 addr  out  7  rdata[6:0] when the last read had rs_sel=0, else holds its previous value.
REQ-013 valid  out  1  one-cycle pulse: rdata/bf/addr updated and transaction complete.
REQ-014 timeout  out  1  one-cycle pulse: poll ended after POLL_MAX reads with BF still 1.
REQ-015 busy  out  1  high from the cycle after req acceptance until valid/timeout.
REQ-016 lcde, lcdrs, lcdrw  out  1 each  LCD E, RS, R/W pins.
REQ-017 lcddata_in  in  8  LCD data bus input side.
REQ-018 lcddata_oe  out  1  host bus drive enable; 0 whenever the reader is not idle.

Function
REQ-019 FSM states: IDLE, SETUP, ENABLE, HOLD, DONE.
REQ-020 IDLE: lcde=0, lcdrw=0, lcddata_oe=1, busy=0; req=1 captures rs_sel/poll and enters SETUP next cycle.
REQ-021 SETUP: lcdrw=1, lcdrs=captured rs_sel, lcddata_oe=0, lcde=0 for exactly T_SETUP cycles, then ENABLE.
REQ-022 ENABLE: lcde=1 for exactly T_EHIGH cycles; lcddata_in registered into rdata on the final ENABLE cycle; then HOLD.
REQ-023 HOLD: lcde=0, lcdrw=1, RS unchanged for T_HOLD cycles; then DONE, or SETUP if a poll is continuing.
REQ-024 Poll continues when poll=1, rs_sel=0, sampled BF=1 and read count < POLL_MAX; re-entry to SETUP does not pulse valid.
REQ-025 DONE: one cycle; pulses valid (or timeout if the poll limit was hit with BF=1, never both); returns to IDLE with lcdrw=0.
REQ-026 Single-read latency req -> valid: 1+T_SETUP+T_EHIGH+T_HOLD+1 cycles (29 at defaults).
REQ-027 poll=1 with rs_sel=1 is treated as a single data read.
REQ-028 req while busy=1 is ignored; no queuing.
REQ-029 Read counter width ceil(log2(POLL_MAX+1)) bits, saturating, cleared on acceptance of req.
REQ-030 E pulse timing is exact; lcdrs/lcdrw never change while lcde=1.

Reset
REQ-031 On resetn=1 at any time: state=IDLE, lcde=0, lcdrs=0, lcdrw=0, lcddata_oe=1, rdata=0, bf=0, addr=0, valid=0, timeout=0, busy=0, counters=0.
REQ-032 Reset asserted mid-transaction drops lcde in the same cycle asynchronously; no valid or timeout is emitted for the aborted read.

Structure
REQ-033 State encodings and default timing constants reside in the shared LCD package/include used by the LCD write controller.
REQ-034 One sub-module lcd_timer: loadable down-counter with terminal-count flag, shared by SETUP/ENABLE/HOLD.

Verification
REQ-035 Single BF read, LCD model drives 0x25: req pulse -> valid at cycle 29, bf=0, addr=0x25, rdata=0x25, lcde high exactly 12 cycles.
REQ-036 Data read rs_sel=1, bus 0x41: lcdrs=1 throughout, rdata=0x41, bf/addr unchanged from prior values.
REQ-037 Poll, model returns 0x80 for 3 reads then 0x07: 4 E pulses, one valid, bf=0, addr=0x07, no timeout.
REQ-038 Poll with POLL_MAX=5, model stuck at 0x80: exactly 5 E pulses, timeout pulse, no valid, busy drops after DONE.
REQ-039 Reset asserted during ENABLE: lcde=0 immediately, all outputs at reset values, no valid; next req completes normally.
REQ-040 req held high continuously and req pulses during busy: exactly one transaction per IDLE visit, lcddata_oe=0 whenever lcdrw=1.

Source files
------------

// File: rtl/lcd_reader_pkg.sv
// Shared LCD interface definitions: FSM state encoding, default bus timing and
// a counter-width helper used by the reader and its timer.
package lcd_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEnable,
    StHold,
    StDone
  } lcd_state_e;

  localparam int unsigned LCD_T_SETUP  = 3;
  localparam int unsigned LCD_T_EHIGH  = 12;
  localparam int unsigned LCD_T_HOLD   = 12;
  localparam int unsigned LCD_POLL_MAX = 4000;

  // Bits needed to hold values 0..v inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v == 0) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module lcd_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780-style bus reader: single byte reads or busy-flag polling with exact
// E pulse timing. resetn is an active-high asynchronous reset.
module lcd_reader
  import lcd_reader_pkg::*;
#(
  parameter int unsigned T_SETUP  = LCD_T_SETUP,
  parameter int unsigned T_EHIGH  = LCD_T_EHIGH,
  parameter int unsigned T_HOLD   = LCD_T_HOLD,
  parameter int unsigned POLL_MAX = LCD_POLL_MAX
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll,
  output logic [7:0] rdata,
  output logic       bf,
  output logic [6:0] addr,
  output logic       valid,
  output logic       timeout,
  output logic       busy,
  output logic       lcde,
  output logic       lcdrs,
  output logic       lcdrw,
  input  logic [7:0] lcddata_in,
  output logic       lcddata_oe
);

  localparam int unsigned TW = cnt_width(T_SETUP + T_EHIGH + T_HOLD);
  localparam int unsigned CW = cnt_width(POLL_MAX);

  localparam logic [TW-1:0] SetupLd  = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] EhighLd  = TW'(T_EHIGH - 1);
  localparam logic [TW-1:0] HoldLd   = TW'(T_HOLD - 1);
  localparam logic [CW-1:0] PollMaxC = CW'(POLL_MAX);

  lcd_state_e    r_state;
  logic          r_poll;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_rdata;
  logic          r_bf;
  logic [6:0]    r_addr;
  logic          r_valid;
  logic          r_timeout;
  logic          r_busy;
  logic          r_lcde;
  logic          r_lcdrs;
  logic          r_lcdrw;
  logic          r_oe;

  logic          w_tc;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_poll_more;

  // r_rdata already holds the byte sampled at the end of ENABLE while in HOLD.
  assign w_poll_more = r_poll && r_rdata[7] && (r_cnt < PollMaxC);

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      StIdle: begin
        if (req) begin
          w_load     = 1'b1;
          w_load_val = SetupLd;
        end
      end
      StSetup: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = EhighLd;
        end
      end
      StEnable: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = HoldLd;
        end
      end
      StHold: begin
        if (w_tc && w_poll_more) begin
          w_load     = 1'b1;
          w_load_val = SetupLd;
        end
      end
      default: ;
    endcase
  end

  lcd_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state   <= StIdle;
      r_poll    <= 1'b0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_bf      <= 1'b0;
      r_addr    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_lcde    <= 1'b0;
      r_lcdrs   <= 1'b0;
      r_lcdrw   <= 1'b0;
      r_oe      <= 1'b1;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req) begin
            r_state <= StSetup;
            // A poll request on the data register degenerates to one read.
            r_poll  <= poll && !rs_sel;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_lcdrs <= rs_sel;
            r_lcdrw <= 1'b1;
            r_oe    <= 1'b0;
          end
        end
        StSetup: begin
          if (w_tc) begin
            r_state <= StEnable;
            r_lcde  <= 1'b1;
          end
        end
        StEnable: begin
          if (w_tc) begin
            r_state <= StHold;
            r_lcde  <= 1'b0;
            r_rdata <= lcddata_in;
            if (!r_lcdrs) begin
              r_bf   <= lcddata_in[7];
              r_addr <= lcddata_in[6:0];
            end
            if (r_cnt != '1) begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        StHold: begin
          if (w_tc) begin
            if (w_poll_more) begin
              r_state <= StSetup;
            end else begin
              r_state <= StDone;
              if (r_poll && r_rdata[7]) begin
                r_timeout <= 1'b1;
              end else begin
                r_valid <= 1'b1;
              end
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_lcdrs <= 1'b0;
          r_lcdrw <= 1'b0;
          r_oe    <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rdata      = r_rdata;
  assign bf         = r_bf;
  assign addr       = r_addr;
  assign valid      = r_valid;
  assign timeout    = r_timeout;
  assign busy       = r_busy;
  assign lcde       = r_lcde;
  assign lcdrs      = r_lcdrs;
  assign lcdrw      = r_lcdrw;
  assign lcddata_oe = r_oe;

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: directed and randomized reads against a
// transaction-level model of the expected bus behaviour and results.
module tb_lcd_reader;

  localparam int TS = 3;
  localparam int TE = 12;
  localparam int TH = 12;
  localparam int PM = 5;

  logic       clk;
  logic       resetn;
  logic       req;
  logic       rs_sel;
  logic       poll;
  logic [7:0] rdata;
  logic       bf;
  logic [6:0] addr;
  logic       valid;
  logic       timeout;
  logic       busy;
  logic       lcde;
  logic       lcdrs;
  logic       lcdrw;
  logic [7:0] lcddata_in;
  logic       lcddata_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_rdata = 8'h00;
  logic       m_bf    = 1'b0;
  logic [6:0] m_addr  = 7'h00;

  lcd_reader #(
    .POLL_MAX (PM)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .rs_sel     (rs_sel),
    .poll       (poll),
    .rdata      (rdata),
    .bf         (bf),
    .addr       (addr),
    .valid      (valid),
    .timeout    (timeout),
    .busy       (busy),
    .lcde       (lcde),
    .lcdrs      (lcdrs),
    .lcdrw      (lcdrw),
    .lcddata_in (lcddata_in),
    .lcddata_oe (lcddata_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the next IDLE cycle.
  task automatic run_txn(input logic rs, input logic pl, input int nbusy,
                         input logic [7:0] busyb, input logic [7:0] lastb,
                         input logic hold, input logic junk);
    logic [7:0] seq[$];
    logic [7:0] last;
    logic       is_poll, exp_to, prev_e, seen, got_v, got_t;
    int         n, lat, cyc, pulses, hi;
    is_poll = pl && !rs;
    if (is_poll) begin
      for (int k = 0; k < nbusy; k++) seq.push_back(busyb | 8'h80);
      seq.push_back(lastb & 8'h7f);
      n = (nbusy + 1 < PM) ? nbusy + 1 : PM;
    end else begin
      seq.push_back(lastb);
      n = 1;
    end
    last   = seq[n-1];
    exp_to = is_poll && last[7];
    lat    = n * (TS + TE + TH) + 2;

    req = 1'b1; rs_sel = rs; poll = pl;
    cyc = 1; pulses = 0; hi = 0; prev_e = 1'b0; seen = 1'b0; got_v = 1'b0; got_t = 1'b0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (!hold) req = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) begin
        rs_sel = 1'($urandom_range(0, 1));
        poll   = 1'($urandom_range(0, 1));
      end
      if (lcde && !prev_e) begin
        lcddata_in = (pulses < seq.size()) ? seq[pulses] : 8'h00;
        pulses++;
        hi = 0;
      end
      if (lcde) begin
        hi++;
        chk("rs_during_e", 32'(lcdrs), 32'(rs));
        chk("rw_during_e", 32'(lcdrw), 32'd1);
      end
      if (!lcde && prev_e) chk("e_high_len", hi, TE);
      if (lcdrw) chk("oe_while_rw", 32'(lcddata_oe), 32'd0);
      chk("busy_in_txn", 32'(busy), 32'd1);
      if (valid || timeout) begin
        chk("valid_and_timeout", 32'(valid && timeout), 32'd0);
        seen  = 1'b1;
        got_v = valid;
        got_t = timeout;
      end
      prev_e = lcde;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", cyc, lat);
    chk("e_pulses", pulses, n);
    chk("valid_pulse", 32'(got_v), 32'(!exp_to));
    chk("timeout_pulse", 32'(got_t), 32'(exp_to));
    m_rdata = last;
    if (!rs) begin
      m_bf   = last[7];
      m_addr = last[6:0];
    end
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("bf", 32'(bf), 32'(m_bf));
    chk("addr", 32'(addr), 32'(m_addr));

    @(negedge clk);
    req = hold;
    chk("idle_valid", 32'(valid), 32'd0);
    chk("idle_timeout", 32'(timeout), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_oe", 32'(lcddata_oe), 32'd1);
    chk("idle_rw", 32'(lcdrw), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_lcde", 32'(lcde), 32'd0);
    chk("rst_lcdrs", 32'(lcdrs), 32'd0);
    chk("rst_lcdrw", 32'(lcdrw), 32'd0);
    chk("rst_oe", 32'(lcddata_oe), 32'd1);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_bf", 32'(bf), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic any_done;
    resetn = 1'b1; req = 1'b0; rs_sel = 1'b0; poll = 1'b0; lcddata_in = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    resetn = 1'b0;
    @(negedge clk);

    // Directed scenarios
    run_txn(1'b0, 1'b0, 0, 8'h80, 8'h25, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 0, 8'h80, 8'h41, 1'b0, 1'b0);
    run_txn(1'b1, 1'b1, 3, 8'h80, 8'hc1, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 3, 8'h80, 8'h07, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 10, 8'h80, 8'h07, 1'b0, 1'b0);
    run_txn(1'b0, 1'b0, 0, 8'h80, 8'hb3, 1'b0, 1'b0);

    // req held high across back-to-back transactions
    run_txn(1'b0, 1'b0, 0, 8'h80, 8'h9a, 1'b1, 1'b0);
    run_txn(1'b1, 1'b0, 0, 8'h80, 8'h33, 1'b1, 1'b0);
    run_txn(1'b0, 1'b1, 2, 8'h85, 8'h11, 1'b0, 1'b0);

    // Randomized reads with req/rs_sel/poll noise while busy
    for (int i = 0; i < 30; i++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom), 1'b0, 1'b1);
    end

    // Reset in the middle of the E pulse
    req = 1'b1; rs_sel = 1'b0; poll = 1'b1;
    @(negedge clk);
    req = 1'b0;
    lcddata_in = 8'h80;
    repeat (6) @(negedge clk);
    chk("pre_reset_lcde", 32'(lcde), 32'd1);
    #2 resetn = 1'b1;
    #1 chk_reset_outputs();
    m_rdata = 8'h00; m_bf = 1'b0; m_addr = 7'h00;
    @(negedge clk);
    resetn = 1'b0;
    any_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid || timeout || lcde) any_done = 1'b1;
    end
    chk("no_activity_after_reset", 32'(any_done), 32'd0);
    run_txn(1'b0, 1'b0, 0, 8'h80, 8'h25, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
